// File: rtl/memory_access_pkg.sv
// ============================================================================
// memory_access_pkg : shared encodings and types for the MEM pipeline stage
// Revision: 1.0
// ============================================================================
`default_nettype none

package memory_access_pkg;

   localparam logic [1:0] LS_SIZE_BYTE = 2'd0;
   localparam logic [1:0] LS_SIZE_HALF = 2'd1;
   localparam logic [1:0] LS_SIZE_WORD = 2'd2;

   localparam logic [3:0] ECAUSE_LOAD_MISALIGNED  = 4'd4;
   localparam logic [3:0] ECAUSE_STORE_MISALIGNED = 4'd6;

   typedef enum logic [1:0] {
      MEM_STATE_IDLE     = 2'd0,
      MEM_STATE_REQUEST  = 2'd1,
      MEM_STATE_RESPONSE = 2'd2,
      MEM_STATE_DONE     = 2'd3
   } mem_state_e;

   typedef struct packed {
      logic [31:0] pc;
      logic [31:0] next_pc;
      logic [31:0] alu_data;
      logic [31:0] csr_data;
      logic        branch_taken;
      logic [1:0]  write_select;
      logic [4:0]  rd_address;
      logic [11:0] csr_address;
      logic        csr_write;
      logic        mret;
      logic        wfi;
      logic [3:0]  ecause;
      logic        exception;
   } stage_fields_t;

endpackage

`default_nettype wire

// File: rtl/memory_access_load_store_align.sv
// ============================================================================
// memory_access_load_store_align : byte-lane steering, load extension and
// misalignment detection for the MEM stage.  Purely combinational.
// Revision: 1.0
// ============================================================================
`default_nettype none

module memory_access_load_store_align
   import memory_access_pkg::*;
#(
   parameter bit MISALIGNED_TRAP = 1'b1
) (
   input  logic [1:0]  size_i,
   input  logic        signed_i,
   input  logic [1:0]  offset_i,
   input  logic [31:0] rs2_i,
   input  logic [31:0] rdata_i,
   output logic [31:0] wdata_o,
   output logic [3:0]  strobe_o,
   output logic [31:0] ldata_o,
   output logic        misaligned_o
);

   logic        w_raw;
   logic [1:0]  w_off;
   logic [31:0] w_shift;

   always_comb begin
      w_raw        = ((size_i == LS_SIZE_HALF) && offset_i[0]) ||
                     ((size_i == LS_SIZE_WORD) && (offset_i != 2'b00));
      misaligned_o = MISALIGNED_TRAP && w_raw;
      // With trapping disabled a misaligned access is issued as if aligned.
      w_off        = (w_raw && !MISALIGNED_TRAP) ? 2'b00 : offset_i;
      w_shift      = rdata_i;
      wdata_o      = rs2_i;
      strobe_o     = 4'b1111;
      ldata_o      = rdata_i;
      case (size_i)
         LS_SIZE_BYTE: begin
            wdata_o  = {4{rs2_i[7:0]}};
            strobe_o = 4'b0001 << w_off;
            w_shift  = rdata_i >> {w_off, 3'b000};
            ldata_o  = {{24{signed_i & w_shift[7]}}, w_shift[7:0]};
         end
         LS_SIZE_HALF: begin
            wdata_o  = {2{rs2_i[15:0]}};
            strobe_o = 4'b0011 << {w_off[1], 1'b0};
            w_shift  = rdata_i >> {w_off[1], 4'b0000};
            ldata_o  = {{16{signed_i & w_shift[15]}}, w_shift[15:0]};
         end
         default: ;
      endcase
   end

endmodule

`default_nettype wire

// File: rtl/memory_access.sv
// ============================================================================
// memory_access : MEM pipeline stage - data-memory request/response handling,
// result alignment and forwarding of execute results to writeback.
// Revision: 1.0
// ============================================================================
`default_nettype none

module memory_access
   import memory_access_pkg::*;
#(
   parameter bit MISALIGNED_TRAP = 1'b1
) (
   input  logic        clk,
   input  logic        reset_n,
   input  logic [31:0] pc_in,
   input  logic [31:0] next_pc_in,
   input  logic [31:0] alu_data_in,
   input  logic [31:0] rs2_data_in,
   input  logic [31:0] csr_data_in,
   input  logic        branch_taken_in,
   input  logic        load_in,
   input  logic        store_in,
   input  logic [1:0]  load_store_size_in,
   input  logic        load_signed_in,
   input  logic [1:0]  write_select_in,
   input  logic [4:0]  rd_address_in,
   input  logic [11:0] csr_address_in,
   input  logic        csr_write_in,
   input  logic        mret_in,
   input  logic        wfi_in,
   input  logic        valid_in,
   input  logic [3:0]  ecause_in,
   input  logic        exception_in,
   input  logic        stall,
   input  logic        invalidate,
   output logic        mem_busy,
   output logic        mem_req_valid,
   input  logic        mem_req_ready,
   output logic        mem_req_write,
   output logic [31:0] mem_req_address,
   output logic [31:0] mem_req_wdata,
   output logic [3:0]  mem_req_strobe,
   input  logic        mem_resp_valid,
   input  logic [31:0] mem_resp_rdata,
   output logic [31:0] pc_out,
   output logic [31:0] next_pc_out,
   output logic [31:0] alu_data_out,
   output logic [31:0] csr_data_out,
   output logic        branch_taken_out,
   output logic [1:0]  write_select_out,
   output logic [4:0]  rd_address_out,
   output logic [11:0] csr_address_out,
   output logic        csr_write_out,
   output logic        mret_out,
   output logic        wfi_out,
   output logic        valid_out,
   output logic [3:0]  ecause_out,
   output logic        exception_out,
   output logic [31:0] load_data_out
);

   mem_state_e    state_q, state_d;
   stage_fields_t fields_q, out_q, w_in_fields;
   logic          load_q, signed_q, kill_q, valid_out_q;
   logic [1:0]    size_q;
   logic          req_valid_q, req_write_q;
   logic [31:0]   req_address_q, req_wdata_q, rdata_q, load_data_q;
   logic [3:0]    req_strobe_q;

   logic          w_latched, w_is_mem, w_misaligned, w_trap, w_access;
   logic          w_start, w_capture, w_finish, w_signed;
   logic [1:0]    w_size, w_offset;
   logic [31:0]   w_rdata, w_wdata, w_ldata;
   logic [3:0]    w_strobe;

   // Alignment logic sees the live instruction in IDLE and the latched one afterwards.
   assign w_latched = (state_q != MEM_STATE_IDLE);
   assign w_size    = w_latched ? size_q : load_store_size_in;
   assign w_signed  = w_latched ? signed_q : load_signed_in;
   assign w_offset  = w_latched ? fields_q.alu_data[1:0] : alu_data_in[1:0];
   assign w_rdata   = (state_q == MEM_STATE_DONE) ? rdata_q : mem_resp_rdata;

   memory_access_load_store_align #(
      .MISALIGNED_TRAP(MISALIGNED_TRAP)
   ) u_align (
      .size_i      (w_size),
      .signed_i    (w_signed),
      .offset_i    (w_offset),
      .rs2_i       (rs2_data_in),
      .rdata_i     (w_rdata),
      .wdata_o     (w_wdata),
      .strobe_o    (w_strobe),
      .ldata_o     (w_ldata),
      .misaligned_o(w_misaligned)
   );

   assign w_is_mem = load_in || store_in;
   assign w_trap   = valid_in && w_is_mem && w_misaligned;
   assign w_access = valid_in && w_is_mem && !exception_in && !w_misaligned && !invalidate;
   assign mem_busy = w_latched || w_access;

   always_comb begin
      w_in_fields = '{pc: pc_in, next_pc: next_pc_in, alu_data: alu_data_in,
                      csr_data: csr_data_in, branch_taken: branch_taken_in,
                      write_select: write_select_in, rd_address: rd_address_in,
                      csr_address: csr_address_in, csr_write: csr_write_in,
                      mret: mret_in, wfi: wfi_in, ecause: ecause_in,
                      exception: exception_in};
      if (w_trap && !exception_in) begin
         w_in_fields.exception = 1'b1;
         w_in_fields.ecause    = store_in ? ECAUSE_STORE_MISALIGNED : ECAUSE_LOAD_MISALIGNED;
      end
   end

   always_comb begin
      state_d   = state_q;
      w_start   = 1'b0;
      w_capture = 1'b0;
      w_finish  = 1'b0;
      case (state_q)
         MEM_STATE_IDLE: begin
            if (w_access && !stall) begin
               w_start = 1'b1;
               state_d = MEM_STATE_REQUEST;
            end
         end
         MEM_STATE_REQUEST: begin
            if (mem_req_ready) state_d = MEM_STATE_RESPONSE;
         end
         MEM_STATE_RESPONSE: begin
            if (mem_resp_valid) begin
               if (!stall) begin
                  w_finish = 1'b1;
                  state_d  = MEM_STATE_IDLE;
               end else begin
                  w_capture = 1'b1;
                  state_d   = MEM_STATE_DONE;
               end
            end
         end
         default: begin
            if (!stall) begin
               w_finish = 1'b1;
               state_d  = MEM_STATE_IDLE;
            end
         end
      endcase
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) state_q <= MEM_STATE_IDLE;
      else          state_q <= state_d;
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         fields_q      <= '0;
         out_q         <= '0;
         load_q        <= 1'b0;
         signed_q      <= 1'b0;
         size_q        <= 2'b00;
         kill_q        <= 1'b0;
         valid_out_q   <= 1'b0;
         req_valid_q   <= 1'b0;
         req_write_q   <= 1'b0;
         req_address_q <= '0;
         req_wdata_q   <= '0;
         req_strobe_q  <= '0;
         rdata_q       <= '0;
         load_data_q   <= '0;
      end else begin
         if (w_start) begin
            fields_q      <= w_in_fields;
            load_q        <= load_in;
            signed_q      <= load_signed_in;
            size_q        <= load_store_size_in;
            req_valid_q   <= 1'b1;
            req_write_q   <= store_in;
            req_address_q <= {alu_data_in[31:2], 2'b00};
            req_wdata_q   <= store_in ? w_wdata : 32'h0;
            req_strobe_q  <= store_in ? w_strobe : 4'b1111;
         end else if ((state_q == MEM_STATE_REQUEST) && mem_req_ready) begin
            req_valid_q <= 1'b0;
         end

         if (w_capture) rdata_q <= mem_resp_rdata;

         // A killed transaction still runs on the bus; only its result is dropped.
         if (state_d == MEM_STATE_IDLE)   kill_q <= 1'b0;
         else if (w_latched && invalidate) kill_q <= 1'b1;

         if (!stall) begin
            if (w_finish) begin
               out_q       <= fields_q;
               valid_out_q <= !(kill_q || invalidate);
               load_data_q <= load_q ? w_ldata : 32'h0;
            end else if (mem_busy) begin
               valid_out_q <= 1'b0;
            end else begin
               out_q       <= w_in_fields;
               valid_out_q <= valid_in && !invalidate;
               load_data_q <= 32'h0;
            end
         end
      end
   end

   assign mem_req_valid    = req_valid_q;
   assign mem_req_write    = req_write_q;
   assign mem_req_address  = req_address_q;
   assign mem_req_wdata    = req_wdata_q;
   assign mem_req_strobe   = req_strobe_q;
   assign pc_out           = out_q.pc;
   assign next_pc_out      = out_q.next_pc;
   assign alu_data_out     = out_q.alu_data;
   assign csr_data_out     = out_q.csr_data;
   assign branch_taken_out = out_q.branch_taken;
   assign write_select_out = out_q.write_select;
   assign rd_address_out   = out_q.rd_address;
   assign csr_address_out  = out_q.csr_address;
   assign csr_write_out    = out_q.csr_write;
   assign mret_out         = out_q.mret;
   assign wfi_out          = out_q.wfi;
   assign ecause_out       = out_q.ecause;
   assign exception_out    = out_q.exception;
   assign valid_out        = valid_out_q;
   assign load_data_out    = load_data_q;

endmodule

`default_nettype wire

// File: tb/tb_memory_access.sv
// ============================================================================
// tb_memory_access : directed self-checking bench for memory_access
// Revision: 1.0
// ============================================================================
`default_nettype none

module tb_memory_access;

   logic        clk, reset_n;
   logic [31:0] pc_in, next_pc_in, alu_data_in, rs2_data_in, csr_data_in;
   logic        branch_taken_in, load_in, store_in, load_signed_in;
   logic [1:0]  load_store_size_in, write_select_in;
   logic [4:0]  rd_address_in;
   logic [11:0] csr_address_in;
   logic        csr_write_in, mret_in, wfi_in, valid_in, exception_in;
   logic [3:0]  ecause_in;
   logic        stall, invalidate;
   logic        mem_busy, mem_req_valid, mem_req_ready, mem_req_write;
   logic [31:0] mem_req_address, mem_req_wdata;
   logic [3:0]  mem_req_strobe;
   logic        mem_resp_valid;
   logic [31:0] mem_resp_rdata;
   logic [31:0] pc_out, next_pc_out, alu_data_out, csr_data_out, load_data_out;
   logic        branch_taken_out, csr_write_out, mret_out, wfi_out, valid_out, exception_out;
   logic [1:0]  write_select_out;
   logic [4:0]  rd_address_out;
   logic [11:0] csr_address_out;
   logic [3:0]  ecause_out;

   int errors = 0;
   int checks = 0;

   memory_access dut (
      .clk(clk), .reset_n(reset_n),
      .pc_in(pc_in), .next_pc_in(next_pc_in), .alu_data_in(alu_data_in),
      .rs2_data_in(rs2_data_in), .csr_data_in(csr_data_in),
      .branch_taken_in(branch_taken_in), .load_in(load_in), .store_in(store_in),
      .load_store_size_in(load_store_size_in), .load_signed_in(load_signed_in),
      .write_select_in(write_select_in), .rd_address_in(rd_address_in),
      .csr_address_in(csr_address_in), .csr_write_in(csr_write_in),
      .mret_in(mret_in), .wfi_in(wfi_in), .valid_in(valid_in),
      .ecause_in(ecause_in), .exception_in(exception_in),
      .stall(stall), .invalidate(invalidate), .mem_busy(mem_busy),
      .mem_req_valid(mem_req_valid), .mem_req_ready(mem_req_ready),
      .mem_req_write(mem_req_write), .mem_req_address(mem_req_address),
      .mem_req_wdata(mem_req_wdata), .mem_req_strobe(mem_req_strobe),
      .mem_resp_valid(mem_resp_valid), .mem_resp_rdata(mem_resp_rdata),
      .pc_out(pc_out), .next_pc_out(next_pc_out), .alu_data_out(alu_data_out),
      .csr_data_out(csr_data_out), .branch_taken_out(branch_taken_out),
      .write_select_out(write_select_out), .rd_address_out(rd_address_out),
      .csr_address_out(csr_address_out), .csr_write_out(csr_write_out),
      .mret_out(mret_out), .wfi_out(wfi_out), .valid_out(valid_out),
      .ecause_out(ecause_out), .exception_out(exception_out),
      .load_data_out(load_data_out)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic set_nop();
      pc_in = 32'h0; next_pc_in = 32'h0; alu_data_in = 32'h0; rs2_data_in = 32'h0;
      csr_data_in = 32'h0; branch_taken_in = 1'b0; load_in = 1'b0; store_in = 1'b0;
      load_store_size_in = 2'd0; load_signed_in = 1'b0; write_select_in = 2'd0;
      rd_address_in = 5'd0; csr_address_in = 12'h0; csr_write_in = 1'b0;
      mret_in = 1'b0; wfi_in = 1'b0; valid_in = 1'b0; ecause_in = 4'd0;
      exception_in = 1'b0; stall = 1'b0; invalidate = 1'b0;
      mem_req_ready = 1'b1; mem_resp_valid = 1'b0; mem_resp_rdata = 32'h0;
   endtask

   task automatic set_op(input logic [31:0] pc, input logic ld, input logic st,
                         input logic [1:0] size, input logic sgn,
                         input logic [31:0] addr, input logic [31:0] rs2);
      set_nop();
      pc_in = pc; next_pc_in = pc + 32'd4; alu_data_in = addr; rs2_data_in = rs2;
      load_in = ld; store_in = st; load_store_size_in = size; load_signed_in = sgn;
      rd_address_in = 5'd9; write_select_in = 2'd1; valid_in = 1'b1;
   endtask

   // Three-edge access with a bus that accepts and responds immediately.
   task automatic run_mem(input logic [31:0] rdata);
      tick();
      set_nop();
      tick();
      mem_resp_valid = 1'b1; mem_resp_rdata = rdata;
      tick();
      mem_resp_valid = 1'b0;
   endtask

   task automatic test_reset();
      reset_n = 1'b0;
      set_nop();
      #12;
      checks++; if (valid_out !== 1'b0) begin errors++; $display("FAIL reset_valid: got %b want 0", valid_out); end
      checks++; if (mem_req_valid !== 1'b0) begin errors++; $display("FAIL reset_req_valid: got %b want 0", mem_req_valid); end
      checks++; if (exception_out !== 1'b0) begin errors++; $display("FAIL reset_exc: got %b want 0", exception_out); end
      checks++; if (load_data_out !== 32'h0) begin errors++; $display("FAIL reset_ldata: got %h want 0", load_data_out); end
      checks++; if (mem_busy !== 1'b0) begin errors++; $display("FAIL reset_busy: got %b want 0", mem_busy); end
      @(negedge clk);
      reset_n = 1'b1;
      tick();
   endtask

   task automatic test_load_word();
      set_op(32'h1000, 1'b1, 1'b0, 2'd2, 1'b0, 32'h100, 32'h0);
      #1;
      checks++; if (mem_busy !== 1'b1) begin errors++; $display("FAIL lw_busy: got %b want 1", mem_busy); end
      tick();
      set_nop();
      checks++; if (mem_req_valid !== 1'b1) begin errors++; $display("FAIL lw_req_valid: got %b want 1", mem_req_valid); end
      checks++; if (mem_req_address !== 32'h100) begin errors++; $display("FAIL lw_addr: got %h want 00000100", mem_req_address); end
      checks++; if (mem_req_write !== 1'b0) begin errors++; $display("FAIL lw_write: got %b want 0", mem_req_write); end
      checks++; if (mem_req_strobe !== 4'b1111) begin errors++; $display("FAIL lw_strobe: got %b want 1111", mem_req_strobe); end
      tick();
      checks++; if (mem_req_valid !== 1'b0) begin errors++; $display("FAIL lw_req_drop: got %b want 0", mem_req_valid); end
      checks++; if (valid_out !== 1'b0) begin errors++; $display("FAIL lw_bubble: got %b want 0", valid_out); end
      mem_resp_valid = 1'b1; mem_resp_rdata = 32'h8765_4321;
      tick();
      mem_resp_valid = 1'b0;
      checks++; if (valid_out !== 1'b1) begin errors++; $display("FAIL lw_valid: got %b want 1", valid_out); end
      checks++; if (load_data_out !== 32'h8765_4321) begin errors++; $display("FAIL lw_ldata: got %h want 87654321", load_data_out); end
      checks++; if (pc_out !== 32'h1000) begin errors++; $display("FAIL lw_pc: got %h want 00001000", pc_out); end
      checks++; if (rd_address_out !== 5'd9) begin errors++; $display("FAIL lw_rd: got %0d want 9", rd_address_out); end
      checks++; if (mem_busy !== 1'b0) begin errors++; $display("FAIL lw_idle: got %b want 0", mem_busy); end
   endtask

   task automatic test_load_extend();
      set_op(32'h1010, 1'b1, 1'b0, 2'd0, 1'b1, 32'h103, 32'h0);
      run_mem(32'h8012_3456);
      checks++; if (load_data_out !== 32'hFFFF_FF80) begin errors++; $display("FAIL lb_ldata: got %h want ffffff80", load_data_out); end
      checks++; if (valid_out !== 1'b1) begin errors++; $display("FAIL lb_valid: got %b want 1", valid_out); end
      set_op(32'h1014, 1'b1, 1'b0, 2'd1, 1'b0, 32'h102, 32'h0);
      run_mem(32'hBEEF_0000);
      checks++; if (load_data_out !== 32'h0000_BEEF) begin errors++; $display("FAIL lhu_ldata: got %h want 0000beef", load_data_out); end
      set_op(32'h1018, 1'b1, 1'b0, 2'd1, 1'b1, 32'h102, 32'h0);
      run_mem(32'hBEEF_0000);
      checks++; if (load_data_out !== 32'hFFFF_BEEF) begin errors++; $display("FAIL lh_ldata: got %h want ffffbeef", load_data_out); end
      set_op(32'h101C, 1'b1, 1'b0, 2'd0, 1'b0, 32'h101, 32'h0);
      run_mem(32'h1122_F344);
      checks++; if (load_data_out !== 32'h0000_00F3) begin errors++; $display("FAIL lbu_ldata: got %h want 000000f3", load_data_out); end
   endtask

   task automatic test_store();
      set_op(32'h1020, 1'b0, 1'b1, 2'd0, 1'b0, 32'h201, 32'h0000_00AB);
      tick();
      checks++; if (mem_req_wdata !== 32'hABAB_ABAB) begin errors++; $display("FAIL sb_wdata: got %h want abababab", mem_req_wdata); end
      checks++; if (mem_req_strobe !== 4'b0010) begin errors++; $display("FAIL sb_strobe: got %b want 0010", mem_req_strobe); end
      checks++; if (mem_req_write !== 1'b1) begin errors++; $display("FAIL sb_write: got %b want 1", mem_req_write); end
      checks++; if (mem_req_address !== 32'h200) begin errors++; $display("FAIL sb_addr: got %h want 00000200", mem_req_address); end
      set_nop();
      tick();
      mem_resp_valid = 1'b1; mem_resp_rdata = 32'hFFFF_FFFF;
      tick();
      mem_resp_valid = 1'b0;
      checks++; if (valid_out !== 1'b1) begin errors++; $display("FAIL sb_valid: got %b want 1", valid_out); end
      checks++; if (load_data_out !== 32'h0) begin errors++; $display("FAIL sb_ldata: got %h want 0", load_data_out); end
      set_op(32'h1024, 1'b0, 1'b1, 2'd1, 1'b0, 32'h202, 32'h5555_1234);
      tick();
      checks++; if (mem_req_wdata !== 32'h1234_1234) begin errors++; $display("FAIL sh_wdata: got %h want 12341234", mem_req_wdata); end
      checks++; if (mem_req_strobe !== 4'b1100) begin errors++; $display("FAIL sh_strobe: got %b want 1100", mem_req_strobe); end
      set_nop();
      tick();
      mem_resp_valid = 1'b1;
      tick();
      mem_resp_valid = 1'b0;
   endtask

   task automatic test_misaligned();
      set_op(32'h1100, 1'b1, 1'b0, 2'd2, 1'b0, 32'h102, 32'h0);
      #1;
      checks++; if (mem_busy !== 1'b0) begin errors++; $display("FAIL mis_lw_busy: got %b want 0", mem_busy); end
      tick();
      checks++; if (mem_req_valid !== 1'b0) begin errors++; $display("FAIL mis_lw_req: got %b want 0", mem_req_valid); end
      checks++; if (exception_out !== 1'b1) begin errors++; $display("FAIL mis_lw_exc: got %b want 1", exception_out); end
      checks++; if (ecause_out !== 4'd4) begin errors++; $display("FAIL mis_lw_cause: got %0d want 4", ecause_out); end
      checks++; if (valid_out !== 1'b1) begin errors++; $display("FAIL mis_lw_valid: got %b want 1", valid_out); end
      set_op(32'h1104, 1'b0, 1'b1, 2'd1, 1'b0, 32'h301, 32'h0);
      tick();
      checks++; if (ecause_out !== 4'd6) begin errors++; $display("FAIL mis_sh_cause: got %0d want 6", ecause_out); end
      set_op(32'h1108, 1'b1, 1'b0, 2'd2, 1'b0, 32'h102, 32'h0);
      exception_in = 1'b1; ecause_in = 4'd2;
      tick();
      checks++; if (ecause_out !== 4'd2) begin errors++; $display("FAIL upstream_cause: got %0d want 2", ecause_out); end
      set_nop();
      tick();
      checks++; if (exception_out !== 1'b0) begin errors++; $display("FAIL exc_clear: got %b want 0", exception_out); end
   endtask

   task automatic test_backpressure_stall();
      set_op(32'h1200, 1'b1, 1'b0, 2'd2, 1'b0, 32'h104, 32'h0);
      mem_req_ready = 1'b0;
      tick();
      set_nop();
      mem_req_ready = 1'b0;
      repeat (5) tick();
      checks++; if (mem_req_valid !== 1'b1) begin errors++; $display("FAIL bp_req_held: got %b want 1", mem_req_valid); end
      checks++; if (mem_req_address !== 32'h104) begin errors++; $display("FAIL bp_addr: got %h want 00000104", mem_req_address); end
      mem_req_ready = 1'b1;
      tick();
      mem_resp_valid = 1'b1; mem_resp_rdata = 32'hCAFE_F00D; stall = 1'b1;
      tick();
      mem_resp_valid = 1'b0; mem_resp_rdata = 32'hDEAD_BEEF;
      tick();
      checks++; if (valid_out !== 1'b0) begin errors++; $display("FAIL st_hold_valid: got %b want 0", valid_out); end
      checks++; if (mem_busy !== 1'b1) begin errors++; $display("FAIL st_busy: got %b want 1", mem_busy); end
      stall = 1'b0;
      tick();
      checks++; if (valid_out !== 1'b1) begin errors++; $display("FAIL st_valid: got %b want 1", valid_out); end
      checks++; if (load_data_out !== 32'hCAFE_F00D) begin errors++; $display("FAIL st_ldata: got %h want cafef00d", load_data_out); end
      checks++; if (pc_out !== 32'h1200) begin errors++; $display("FAIL st_pc: got %h want 00001200", pc_out); end
      tick();
      checks++; if (valid_out !== 1'b0) begin errors++; $display("FAIL st_once: got %b want 0", valid_out); end
   endtask

   task automatic test_stall_hold();
      set_op(32'h1300, 1'b0, 1'b0, 2'd0, 1'b0, 32'h1234_5678, 32'h0);
      tick();
      checks++; if (alu_data_out !== 32'h1234_5678) begin errors++; $display("FAIL pass_alu: got %h want 12345678", alu_data_out); end
      set_op(32'h1304, 1'b0, 1'b0, 2'd0, 1'b0, 32'h0, 32'h0);
      stall = 1'b1;
      tick();
      checks++; if (pc_out !== 32'h1300) begin errors++; $display("FAIL hold_pc: got %h want 00001300", pc_out); end
      checks++; if (valid_out !== 1'b1) begin errors++; $display("FAIL hold_valid: got %b want 1", valid_out); end
      stall = 1'b0;
      tick();
      checks++; if (pc_out !== 32'h1304) begin errors++; $display("FAIL release_pc: got %h want 00001304", pc_out); end
   endtask

   task automatic test_invalidate();
      set_op(32'h1400, 1'b1, 1'b0, 2'd2, 1'b0, 32'h108, 32'h0);
      tick();
      set_nop();
      tick();
      invalidate = 1'b1;
      tick();
      invalidate = 1'b0; mem_resp_valid = 1'b1; mem_resp_rdata = 32'h1111_2222;
      tick();
      mem_resp_valid = 1'b0;
      checks++; if (valid_out !== 1'b0) begin errors++; $display("FAIL inv_valid: got %b want 0", valid_out); end
      checks++; if (mem_busy !== 1'b0) begin errors++; $display("FAIL inv_busy: got %b want 0", mem_busy); end
      set_op(32'h1404, 1'b0, 1'b0, 2'd0, 1'b0, 32'h0, 32'h0);
      tick();
      checks++; if (valid_out !== 1'b1) begin errors++; $display("FAIL inv_next_valid: got %b want 1", valid_out); end
      checks++; if (pc_out !== 32'h1404) begin errors++; $display("FAIL inv_next_pc: got %h want 00001404", pc_out); end
      set_op(32'h1408, 1'b1, 1'b0, 2'd2, 1'b0, 32'h10C, 32'h0);
      run_mem(32'h3333_4444);
      checks++; if (valid_out !== 1'b1) begin errors++; $display("FAIL inv_after_valid: got %b want 1", valid_out); end
      checks++; if (load_data_out !== 32'h3333_4444) begin errors++; $display("FAIL inv_after_ldata: got %h want 33334444", load_data_out); end
   endtask

   task automatic test_reset_mid();
      set_op(32'h1500, 1'b1, 1'b0, 2'd2, 1'b0, 32'h110, 32'h0);
      mem_req_ready = 1'b0;
      tick();
      set_nop();
      mem_req_ready = 1'b0;
      checks++; if (mem_req_valid !== 1'b1) begin errors++; $display("FAIL mr_req: got %b want 1", mem_req_valid); end
      #2 reset_n = 1'b0;
      #1;
      checks++; if (mem_req_valid !== 1'b0) begin errors++; $display("FAIL mr_req_clear: got %b want 0", mem_req_valid); end
      checks++; if (mem_busy !== 1'b0) begin errors++; $display("FAIL mr_busy: got %b want 0", mem_busy); end
      @(negedge clk);
      reset_n = 1'b1;
      mem_req_ready = 1'b1; mem_resp_valid = 1'b1; mem_resp_rdata = 32'h55;
      tick();
      mem_resp_valid = 1'b0;
      checks++; if (valid_out !== 1'b0) begin errors++; $display("FAIL mr_stray_valid: got %b want 0", valid_out); end
      checks++; if (load_data_out !== 32'h0) begin errors++; $display("FAIL mr_stray_ldata: got %h want 0", load_data_out); end
      checks++; if (mem_busy !== 1'b0) begin errors++; $display("FAIL mr_stray_busy: got %b want 0", mem_busy); end
   endtask

   initial begin
      test_reset();
      test_load_word();
      test_load_extend();
      test_store();
      test_misaligned();
      test_backpressure_stall();
      test_stall_hold();
      test_invalidate();
      test_reset_mid();
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule

`default_nettype wire
